// File: rtl/uart_line_buffer_pkg.sv
// -----------------------------------------------------------------------------
// uart_line_buffer_pkg
//   Shared constants for the UART line-editing stage: the ASCII codes the
//   editor reacts to, the playback FSM state encoding, and small byte
//   classification helpers used by the FSM.
// -----------------------------------------------------------------------------
package uart_line_buffer_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_DEL   = 8'h7F;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  // COLLECT gathers and edits the line; the other three play it back.
  typedef enum logic [1:0] {
    ULB_COLLECT   = 2'd0,
    ULB_SEND_LINE = 2'd1,
    ULB_SEND_CR   = 2'd2,
    ULB_SEND_LF   = 2'd3
  } ulb_state_e;

  // Printable ASCII range that is stored in the line.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_SP) && (b <= ASCII_TILDE);
  endfunction

  // Both BS and DEL erase one character; terminals send either one.
  function automatic logic is_erase(input logic [7:0] b);
    return (b == ASCII_BS) || (b == ASCII_DEL);
  endfunction

endpackage

// File: rtl/uart_line_buffer_line_ram.sv
// -----------------------------------------------------------------------------
// uart_line_buffer_line_ram
//   Character store for one line: DEPTH x 8 bits, synchronous write,
//   asynchronous (combinational) read, so it maps onto distributed RAM.
//   The read is asynchronous so the FSM can load the next character into the
//   tx register on the same edge as the handshake, with no bubble.
// Ports
//   clk      in   1       clock
//   we_i     in   1       write enable
//   waddr_i  in   ADDR_W  write address
//   wdata_i  in   8       write data
//   raddr_i  in   ADDR_W  read address
//   rdata_o  out  8       read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module uart_line_buffer_line_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // No reset: contents are only read back below the current line length.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_line_buffer.sv
// -----------------------------------------------------------------------------
// uart_line_buffer
//   Line-editing stage between uart_rx and uart_tx. Printable bytes are
//   collected into a line buffer, BS/DEL erase the last character, and CR
//   ends the line. The stored line is then played back to uart_tx followed by
//   CR LF, after which the stage returns to collecting.
//
// Handshake (both sides): a byte transfers on a posedge where valid && ready.
//   Ready never depends combinationally on valid. tx_data/tx_data_valid are
//   registered and held stable until tx_data_ready is seen with valid high.
//   Bytes offered on rx while playback is running are not accepted.
//
// Ports
//   clk            in   1      system clock
//   rst            in   1      synchronous reset, active-high
//   rx_data        in   8      byte from uart_rx
//   rx_data_valid  in   1      rx_data valid
//   rx_data_ready  out  1      stage accepts a byte (only while collecting)
//   tx_data        out  8      byte to uart_tx
//   tx_data_valid  out  1      tx_data valid
//   tx_data_ready  in   1      uart_tx accepts tx_data
//   line_len       out  LEN_W  characters currently stored
//   line_overflow  out  1      at least one printable byte dropped this line
//   busy           out  1      playback in progress
//   dbg_state      out  2      current FSM state (ulb_state_e encoding)
// -----------------------------------------------------------------------------
module uart_line_buffer
  import uart_line_buffer_pkg::*;
#(
  parameter  int MAX_LEN = 64,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_valid,
  output logic             rx_data_ready,
  output logic [7:0]       tx_data,
  output logic             tx_data_valid,
  input  logic             tx_data_ready,
  output logic [LEN_W-1:0] line_len,
  output logic             line_overflow,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // RAM address width; MAX_LEN >= 2 keeps this at least one bit.
  localparam int               IDX_W     = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  ulb_state_e       state_q, state_d;
  logic [LEN_W-1:0] line_len_q, line_len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;

  logic             rx_fire;
  logic             tx_fire;
  logic [LEN_W-1:0] idx_next;
  logic             ram_we;
  logic [IDX_W-1:0] ram_raddr;
  logic [7:0]       ram_rdata;

  assign rx_data_ready = (state_q == ULB_COLLECT);
  assign rx_fire       = rx_data_valid && rx_data_ready;
  assign tx_fire       = tx_valid_q && tx_data_ready;
  assign idx_next      = idx_q + ONE_L;

  // While collecting the read port looks at slot 0 so the first character is
  // ready when CR arrives; during playback it looks one ahead of idx. On the
  // last character of a full line idx_next truncates to 0, which is harmless
  // because CR is loaded instead of RAM data on that handshake.
  assign ram_raddr = (state_q == ULB_SEND_LINE) ? idx_next[IDX_W-1:0] : '0;

  // Store only when there is room; the write address is the current length.
  assign ram_we = rx_fire && is_printable(rx_data) && (line_len_q < MAX_LEN_L);

  uart_line_buffer_line_ram #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (IDX_W)
  ) u_line_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (line_len_q[IDX_W-1:0]),
    .wdata_i (rx_data),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    line_len_d = line_len_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    case (state_q)
      ULB_COLLECT: begin
        if (rx_fire) begin
          if (is_printable(rx_data)) begin
            if (line_len_q < MAX_LEN_L) begin
              line_len_d = line_len_q + ONE_L;
            end else begin
              overflow_d = 1'b1;
            end
          end else if (is_erase(rx_data)) begin
            if (line_len_q != '0) begin
              line_len_d = line_len_q - ONE_L;
            end
          end else if (rx_data == ASCII_CR) begin
            tx_valid_d = 1'b1;
            idx_d      = '0;
            if (line_len_q != '0) begin
              tx_data_d = ram_rdata;
              state_d   = ULB_SEND_LINE;
            end else begin
              tx_data_d = ASCII_CR;
              state_d   = ULB_SEND_CR;
            end
          end
          // LF and every other control byte is ignored, so CRLF terminals
          // produce a single line.
        end
      end

      ULB_SEND_LINE: begin
        if (tx_fire) begin
          if (idx_q == (line_len_q - ONE_L)) begin
            tx_data_d = ASCII_CR;
            state_d   = ULB_SEND_CR;
          end else begin
            idx_d     = idx_next;
            tx_data_d = ram_rdata;
          end
        end
      end

      ULB_SEND_CR: begin
        if (tx_fire) begin
          tx_data_d = ASCII_LF;
          state_d   = ULB_SEND_LF;
        end
      end

      ULB_SEND_LF: begin
        if (tx_fire) begin
          tx_valid_d = 1'b0;
          line_len_d = '0;
          overflow_d = 1'b0;
          state_d    = ULB_COLLECT;
        end
      end

      default: begin
        state_d    = ULB_COLLECT;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ULB_COLLECT;
      line_len_q <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_len_q <= line_len_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign line_len      = line_len_q;
  assign line_overflow = overflow_q;
  assign busy          = (state_q != ULB_COLLECT);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_uart_line_buffer
//   Directed bench for uart_line_buffer built with MAX_LEN=4 so the overflow
//   boundary is reachable with short lines. A per-cycle vector table covers
//   the basic "Hi" line; hand-written sequences cover editing, overflow,
//   stalled playback, empty lines and reset during playback. Every accepted
//   tx byte is captured and compared against an expected queue.
// -----------------------------------------------------------------------------
module tb_uart_line_buffer;

  localparam int MAX_LEN = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  // ---------------- clock / reset ----------------
  logic             clk;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_data_valid;
  logic             rx_data_ready;
  logic [7:0]       tx_data;
  logic             tx_data_valid;
  logic             tx_data_ready;
  logic [LEN_W-1:0] line_len;
  logic             line_overflow;
  logic             busy;
  logic [1:0]       dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  uart_line_buffer #(.MAX_LEN(MAX_LEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .line_len      (line_len),
    .line_overflow (line_overflow),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       hold_pend;
  logic [7:0] hold_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_stream(input string name);
    int n;
    chk({name, " byte count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s byte %0d", name, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are stable from 1 time unit after an edge until the next edge, so
  // handshakes are recorded here, just before advancing.
  task automatic tick();
    if (!rst && tx_data_valid && tx_data_ready) got_q.push_back(tx_data);
    hold_pend = !rst && tx_data_valid && !tx_data_ready;
    hold_val  = tx_data;
    @(posedge clk);
    #1;
    if (hold_pend) chk("tx held while stalled", {tx_data_valid, tx_data}, {1'b1, hold_val});
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data       = b;
    rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Runs playback to completion. slow: ready only every third cycle.
  // pulse: offer rx bytes throughout, none of which may be accepted.
  task automatic drain(input bit slow, input bit pulse, output int busy_cycles);
    int k;
    busy_cycles = 0;
    k = 0;
    while ((busy || tx_data_valid) && k < 200) begin
      busy_cycles++;
      if (pulse) chk("rx_data_ready low during playback", rx_data_ready, 1'b0);
      tx_data_ready = slow ? ((k % 3) == 0) : 1'b1;
      rx_data       = 8'h51;
      rx_data_valid = pulse && (k % 2 == 1);
      tick();
      k++;
    end
    if (k >= 200) chk("playback timeout", 32'd1, 32'd0);
    rx_data_valid = 1'b0;
    tx_data_ready = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic             rx_v;
    logic [7:0]       rx_d;
    logic             exp_rxr;
    logic             exp_tv;
    logic [7:0]       exp_td;
    logic [LEN_W-1:0] exp_len;
    logic             exp_busy;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    int bc;

    // "Hi" CR with tx_data_ready high: outputs observed before each edge.
    vecs[0] = '{1'b1, 8'h48, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[1] = '{1'b1, 8'h69, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0};
    vecs[2] = '{1'b1, 8'h0D, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h48, 3'd2, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h69, 3'd2, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h0D, 3'd2, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h0A, 3'd2, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};

    rst           = 1'b1;
    rx_data       = 8'h00;
    rx_data_valid = 1'b0;
    tx_data_ready = 1'b0;
    hold_pend     = 1'b0;
    hold_val      = 8'h00;
    #1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state.
    chk("reset tx_data", tx_data, 8'h00);
    chk("reset tx_data_valid", tx_data_valid, 1'b0);
    chk("reset line_len", line_len, 0);
    chk("reset line_overflow", line_overflow, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset rx_data_ready", rx_data_ready, 1'b1);
    chk("reset state", dbg_state, 2'd0);

    // Table: "Hi" CR, one byte per cycle back out.
    tx_data_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("vec%0d rx_data_ready", i), rx_data_ready, vecs[i].exp_rxr);
      chk($sformatf("vec%0d tx_data_valid", i), tx_data_valid, vecs[i].exp_tv);
      if (vecs[i].exp_tv) chk($sformatf("vec%0d tx_data", i), tx_data, vecs[i].exp_td);
      chk($sformatf("vec%0d line_len", i), line_len, vecs[i].exp_len);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      rx_data       = vecs[i].rx_d;
      rx_data_valid = vecs[i].rx_v;
      tick();
    end
    rx_data_valid = 1'b0;
    expect_str("Hi\r\n");
    chk_stream("hi line");

    // Editing: BS on empty line, then "abc" BS DEL "z".
    send_byte(8'h08);
    chk("bs at empty line_len", line_len, 0);
    send_str("abc");
    chk("abc line_len", line_len, 3);
    send_byte(8'h08);
    chk("after BS line_len", line_len, 2);
    send_byte(8'h7F);
    chk("after DEL line_len", line_len, 1);
    send_str("z\r");
    chk("edit busy after CR", busy, 1'b1);
    drain(1'b0, 1'b0, bc);
    chk("edit playback cycles", bc, 4);
    chk("edit line_len after", line_len, 0);
    expect_str("az\r\n");
    chk_stream("edit line");

    // Overflow: exactly MAX_LEN chars fit, the next is dropped.
    send_str("1234");
    chk("full line_len", line_len, 4);
    chk("full no overflow", line_overflow, 1'b0);
    send_str("5");
    chk("overflow flag", line_overflow, 1'b1);
    chk("overflow line_len clamped", line_len, 4);
    send_byte(8'h0D);
    chk("overflow kept during playback", line_overflow, 1'b1);
    drain(1'b0, 1'b0, bc);
    chk("overflow playback cycles", bc, 6);
    chk("overflow cleared after LF", line_overflow, 1'b0);
    expect_str("1234\r\n");
    chk_stream("overflow line");

    // Backspace after overflow frees one slot.
    send_str("12345");
    send_byte(8'h08);
    chk("bs after overflow line_len", line_len, 3);
    chk("bs keeps overflow", line_overflow, 1'b1);
    send_str("6");
    chk("refill line_len", line_len, 4);
    send_byte(8'h0D);
    drain(1'b0, 1'b0, bc);
    expect_str("1236\r\n");
    chk_stream("refill line");

    // Stalled playback with rx pulses that must be refused.
    send_str("XYZ\r");
    drain(1'b1, 1'b1, bc);
    chk("stall line_len after", line_len, 0);
    expect_str("XYZ\r\n");
    chk_stream("stalled line");

    // Empty line followed by LF: only CR LF goes out.
    send_byte(8'h0D);
    chk("empty line tx_data", tx_data, 8'h0D);
    drain(1'b0, 1'b0, bc);
    chk("empty line playback cycles", bc, 2);
    send_byte(8'h0A);
    for (int i = 0; i < 5; i++) tick();
    chk("lf ignored tx_data_valid", tx_data_valid, 1'b0);
    chk("lf ignored busy", busy, 1'b0);
    chk("lf ignored line_len", line_len, 0);
    expect_str("\r\n");
    chk_stream("empty line");

    // Reset in the middle of playing back "ABCDEF" (stored as ABCD).
    send_str("ABCDEF\r");
    tx_data_ready = 1'b1;
    tick();
    tick();
    tx_data_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tx_data_ready = 1'b1;
    chk("midreset tx_data_valid", tx_data_valid, 1'b0);
    chk("midreset line_len", line_len, 0);
    chk("midreset line_overflow", line_overflow, 1'b0);
    chk("midreset rx_data_ready", rx_data_ready, 1'b1);
    chk("midreset busy", busy, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("midreset stays idle", tx_data_valid, 1'b0);
    expect_str("AB");
    chk_stream("midreset line");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
